seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Consumes the four BCD digit nibbles produced by the tenths-of-a-second up-counter and drives a common-anode, 4-digit multiplexed 7-segment display.
- Per frame: takes a tear-free snapshot of the digits, time-multiplexes the anodes with a guard interval against ghosting, decodes BCD to segments, applies optional leading-zero blanking, and lights the decimal point.
- Sits between the counter and the board display pins, on the fast system clock.

Parameters:
- CLK_HZ, 100_000_000, frequency of clk_100MHz.
- REFRESH_HZ, 1000, per-digit slot rate. SLOT_CYCLES = CLK_HZ/REFRESH_HZ (integer division).
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off. Constraint: SLOT_CYCLES > GUARD_CYCLES+1.
- DP_DIGIT, 1, digit index whose decimal point is lit (0=ones … 3=thousands). Default 1 renders "XXX.X".

Ports:
- clk_100MHz  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-HIGH despite the name.
- ones  in  4  BCD digit 0, from the slow counter domain (asynchronous to clk_100MHz).
- tens  in  4  BCD digit 1, same domain.
- hundreds  in  4  BCD digit 2, same domain.
- thousands  in  4  BCD digit 3, same domain.
- blank_lz  in  1  1 = enable leading-zero blanking.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- an  out  4  active-low anodes; an[i] drives digit i.
- frame_tick  out  1  one-cycle pulse when a new snapshot is committed.

Behaviour:
- Reset (async, rst_n=1):
  - an=4'hF, seg=7'h7F, dp=1, frame_tick=0.
  - Slot counter=0, digit index=0, snapshot=0, snapshot-pending flag=1.
  - Reset mid-frame aborts the scan immediately; no partial slot completes.
- Input sync: each of the 16 input bits passes through a 2-flop synchronizer. A stability register holds the previous synchronized 16-bit word.
- Snapshot:
  - The pending flag is set on reset and whenever the digit index wraps 3→0.
  - While pending, capture the synchronized word into the shadow registers only in a cycle where it equals the previous cycle's word. In that cycle clear pending and pulse frame_tick.
  - If the inputs never stabilise, the old snapshot stays displayed and pending stays set.
- Scan:
  - The slot counter runs 0..SLOT_CYCLES-1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
  - Frame period = 4*SLOT_CYCLES.
- Guard: while slot counter < GUARD_CYCLES, an=4'hF, seg=7'h7F, dp=1.
- Active part of a slot:
  - an = active-low one-hot of the index, seg = decode(shadow[index]).
  - dp=0 iff index==DP_DIGIT.
- Decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10–15 display a dash, 0111111.
- Leading-zero blanking (blank_lz=1), evaluated on the shadow values:
  - Digit k>DP_DIGIT is blanked iff it and all digits above it are 0.
  - Digits ≤ DP_DIGIT are never blanked.
  - A blanked digit keeps its full slot, with an=4'hF, seg=7'h7F, dp=1.
- Timing: all outputs are registered and lag the slot counter/index by exactly one clock. frame_tick is registered the same way.
- blank_lz is sampled combinationally into the output register each cycle, so a change takes effect on the next active cycle.

Test Plan (CLK_HZ=1000, REFRESH_HZ=100 → SLOT_CYCLES=10, GUARD_CYCLES=2, DP_DIGIT=1):
- Reset: assert rst_n in mid-slot with an=4'b1101 → an=4'hF, seg=7'h7F, dp=1 in the same cycle, before any clock edge. After release, frame_tick pulses once within 4 cycles, given stable inputs.
- Digits 0,1,2,3 (thousands..ones), blank_lz=0 → scan shows:
  - an=1110 seg=0110000 dp=1
  - an=1101 seg=0100100 dp=0
  - an=1011 seg=1111001
  - an=0111 seg=1000000
  - Each digit is active 8 of 10 cycles; frame_tick every 40 cycles.
- Digits 0,0,0,5, blank_lz=1 → the slots for an[3] and an[2] stay 4'hF for the full slot. Tens shows seg=1000000 with dp=0; ones shows 0010010. With blank_lz=0, all four digits are lit.
- Change ones 3→4 while index=2 → display unchanged for the rest of the frame. After the next frame_tick, the ones slot shows 0011001.
- ones=4'hA → ones slot seg=0111111. Independently: toggle ones between 1 and 2 every cycle across the frame boundary → no frame_tick and the old value stays shown. Hold ones at 2 → frame_tick fires within 4 cycles and 0100100 is shown.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: synchronises the BCD digits,
// takes a tear-free per-frame snapshot, and multiplexes anodes with a dark guard interval.
module seg7_scan_driver #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int GUARD_CYCLES = 16,
    parameter int DP_DIGIT     = 1
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int SLOT_CYCLES = CLK_HZ / REFRESH_HZ;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES);
    localparam logic [1:0]    DP_IDX    = 2'(DP_DIGIT);

    logic [15:0]   word;
    logic [15:0]   sync_q1;
    logic [15:0]   sync_q2;
    logic [15:0]   stable_q;
    logic [15:0]   shadow_q;
    logic          pending_q;
    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit_idx;

    logic          slot_wrap;
    logic          frame_wrap;
    logic          capture;
    logic          in_guard;
    logic [3:0]    cur_digit;
    logic [3:0]    blank_vec;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign word = {thousands, hundreds, tens, ones};

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // The digits come from a slow, unrelated clock; stable_q lets us see two equal samples in a row.
    always_ff @(posedge clk_100MHz or posedge rst_n) begin
        if (rst_n) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            stable_q <= '0;
        end else begin
            sync_q1  <= word;
            sync_q2  <= sync_q1;
            stable_q <= sync_q2;
        end
    end

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (digit_idx == 2'd3);
    assign capture    = pending_q && (sync_q2 == stable_q);
    assign in_guard   = (slot_cnt < GUARD_END);

    always_ff @(posedge clk_100MHz or posedge rst_n) begin
        if (rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    // A frame wrap re-arms the snapshot even if the capture of the previous frame never happened.
    always_ff @(posedge clk_100MHz or posedge rst_n) begin
        if (rst_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b1;
        end else begin
            if (capture) begin
                shadow_q <= sync_q2;
            end
            if (frame_wrap) begin
                pending_q <= 1'b1;
            end else if (capture) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        cur_digit = shadow_q[3:0];
        case (digit_idx)
            2'd0:    cur_digit = shadow_q[3:0];
            2'd1:    cur_digit = shadow_q[7:4];
            2'd2:    cur_digit = shadow_q[11:8];
            default: cur_digit = shadow_q[15:12];
        endcase
    end

    // Walk down from the thousands digit; a digit left of the point blanks only while everything above it is zero.
    always_comb begin : blank_calc
        logic all_zero;
        all_zero  = 1'b1;
        blank_vec = '0;
        for (int k = 3; k >= 0; k--) begin
            all_zero = all_zero & (shadow_q[4*k +: 4] == 4'd0);
            if (k > DP_DIGIT) begin
                blank_vec[k] = blank_lz & all_zero;
            end
        end
    end

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!in_guard && !blank_vec[digit_idx]) begin
            an_d  = ~(4'b0001 << digit_idx);
            seg_d = bcd_to_seg(cur_digit);
            dp_d  = (digit_idx != DP_IDX);
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst_n) begin
        if (rst_n) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_tick <= capture;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed digit patterns; per-slot expectations are queued
// at each frame_tick and checked by a phase-tracking monitor.
module tb_seg7_scan_driver;

    localparam int SLOT  = 10;
    localparam int FRAME = 40;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SD = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ones, tens, hundreds, thousands;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int checks   = 0;
    int failures = 0;

    // Entry: {an, seg, dp, lit}
    logic [12:0] exp_q[$];

    seg7_scan_driver #(
        .CLK_HZ(1000), .REFRESH_HZ(100), .GUARD_CYCLES(2), .DP_DIGIT(1)
    ) dut (
        .clk_100MHz(clk), .rst_n(rst),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                              input logic [3:0] te, input logic [3:0] on);
        thousands = th; hundreds = hu; tens = te; ones = on;
    endtask

    task automatic wait_tick(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                got = 1;
                break;
            end
        end
        check({name, "_tick_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_q_empty(input string name);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    // Push one frame of expectations: slot i shows s[i] on an[i], dp lit on slot 1 only.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] lit);
        logic [6:0] s[4];
        logic [3:0] a;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            a = 4'hF;
            a[i] = 1'b0;
            if (lit[i]) exp_q.push_back({a, s[i], (i != 1), 1'b1});
            else        exp_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
        end
    endtask

    task automatic tick_latency(input string name);
        int t;
        t = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (frame_tick && t == 0) t = i;
        end
        check(name, 32'(t >= 1 && t <= 4), 32'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    int          phase    = 0;
    bit          in_frame = 0;
    logic [9:0]  mask     = '0;
    bit          off_bad  = 0;
    logic [11:0] obs      = '0;

    always @(negedge clk) begin
        logic [12:0] e;
        logic [9:0]  exp_mask;
        if (rst) begin
            in_frame = 0;
            phase    = 0;
        end else begin
            if (frame_tick) begin
                phase    = 0;
                in_frame = 1;
            end else if (in_frame) begin
                phase = (phase + 1) % FRAME;
            end
            if (in_frame) begin
                if (phase % SLOT == 0) begin
                    mask    = '0;
                    off_bad = 0;
                end
                if (an != 4'hF) mask[phase % SLOT] = 1'b1;
                else if (seg !== 7'h7F || dp !== 1'b1) off_bad = 1;
                if (phase % SLOT == 5) obs = {an, seg, dp};
                if (phase % SLOT == SLOT - 1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_mask = e[0] ? 10'h3FC : 10'h000;
                    checks++;
                    if (obs !== e[12:1] || mask !== exp_mask || off_bad) begin
                        failures++;
                        $display("FAIL slot%0d: got an=%b seg=%b dp=%b lit_mask=%b dark_bad=%0d expected an=%b seg=%b dp=%b lit_mask=%b",
                                 phase / SLOT, obs[11:8], obs[7:1], obs[0], mask, off_bad,
                                 e[12:9], e[8:2], e[1], exp_mask);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        blank_lz = 1'b0;
        set_digits(4'd0, 4'd1, 4'd2, 4'd3);
        repeat (3) @(negedge clk);
        check("reset_an", an, 4'hF);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_frame_tick", frame_tick, 1'b0);
        rst = 1'b0;
        tick_latency("release_tick_latency");

        // digits 0,1,2,3 no blanking
        wait_tick("f0123");
        push_frame(S3, S2, S1, S0, 4'b1111);
        wait_q_empty("f0123");

        // frame period
        wait_tick("period");
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (frame_tick) break;
        end
        check("frame_period", n, FRAME);

        // leading-zero blanking 0,0,0,5
        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        blank_lz = 1'b1;
        wait_tick("lz_a"); wait_tick("lz_b");
        push_frame(S5, S0, S0, S0, 4'b0011);
        wait_q_empty("lz_on");
        blank_lz = 1'b0;
        wait_tick("lz_off");
        push_frame(S5, S0, S0, S0, 4'b1111);
        wait_q_empty("lz_off");

        // only thousands blanked: 0,7,0,0
        set_digits(4'd0, 4'd7, 4'd0, 4'd0);
        blank_lz = 1'b1;
        wait_tick("lz2_a"); wait_tick("lz2_b");
        push_frame(S0, S0, S7, S0, 4'b0111);
        wait_q_empty("lz_partial");
        blank_lz = 1'b0;

        // ones 3->4 changed while index 2 is on display
        set_digits(4'd0, 4'd1, 4'd2, 4'd3);
        wait_tick("mid_a"); wait_tick("mid_b");
        push_frame(S3, S2, S1, S0, 4'b1111);
        repeat (25) @(negedge clk);
        ones = 4'd4;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (frame_tick) n++;
        end
        check("mid_frame_no_tick", n, 0);
        wait_tick("mid_next");
        push_frame(S4, S2, S1, S0, 4'b1111);
        wait_q_empty("mid_change");

        // invalid code shows a dash
        ones = 4'hA;
        wait_tick("dash_a"); wait_tick("dash_b");
        push_frame(SD, S2, S1, S0, 4'b1111);
        wait_q_empty("dash");

        // inputs never stabilise across a frame boundary
        ones = 4'd1;
        wait_tick("tog_a"); wait_tick("tog_b");
        push_frame(S1, S2, S1, S0, 4'b1111);
        push_frame(S1, S2, S1, S0, 4'b1111);
        repeat (30) @(negedge clk);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            ones = (ones == 4'd1) ? 4'd2 : 4'd1;
            @(negedge clk);
            if (frame_tick) n++;
        end
        check("toggle_no_tick", n, 0);
        check("toggle_queue_done", exp_q.size(), 0);
        ones = 4'd2;
        tick_latency("settle_tick_latency");
        wait_tick("settled");
        push_frame(S2, S2, S1, S0, 4'b1111);
        wait_q_empty("settled");

        // asynchronous reset in the middle of the tens slot
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an == 4'b1101) begin
                n = 1;
                break;
            end
        end
        check("tens_slot_reached", n, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset_an", an, 4'hF);
        check("async_reset_seg", seg, 7'h7F);
        check("async_reset_dp", dp, 1'b1);
        check("async_reset_frame_tick", frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        check("held_reset_an", an, 4'hF);
        rst = 1'b0;
        tick_latency("rereset_tick_latency");
        wait_tick("after_reset");
        push_frame(S2, S2, S1, S0, 4'b1111);
        wait_q_empty("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
